piezo_sched: RTL and testbench

Alert scheduler for the Segway piezo buzzer. It arbitrates between four alert sources: the one-shot power-up chime, over-speed, low battery and normal-mode heartbeat. It selects the winning source each cycle, sequences the 3-note chime, gates tones into a repeating frame pattern, and drives the differential piezo pair directly. It sits between the balance/steer control (level alerts), the auth/power-up logic (chime request) and the buzzer pins.

---
 rtl/piezo_sched.sv | 152 +++++++++++++++
 tb/tb_piezo_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_sched.sv
// piezo_sched: arbitrates buzzer alert sources, sequences the power-up chime and
// drives a frame-gated square wave onto the differential piezo pair.
module piezo_sched #(
  parameter int unsigned FRAME_CYC = 67108864,
  parameter int unsigned NOTE_CYC  = 4194304,
  parameter int unsigned HP_NORM   = 65536,
  parameter int unsigned HP_BATT   = 32768,
  parameter int unsigned HP_OVR    = 16384
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       norm_mode,
  input  logic       ovr_spd,
  input  logic       batt_low,
  input  logic       chime_req,
  output logic       piezo,
  output logic       piezo_n,
  output logic       busy,
  output logic [2:0] src
);

  localparam int unsigned Q      = FRAME_CYC / 4;
  localparam int unsigned HP_NB  = (HP_NORM > HP_BATT) ? HP_NORM : HP_BATT;
  localparam int unsigned HP_MAX = (HP_NB > HP_OVR) ? HP_NB : HP_OVR;
  localparam int unsigned FC_W   = (FRAME_CYC > 2) ? $clog2(FRAME_CYC) : 1;
  localparam int unsigned NC_W   = (NOTE_CYC > 2) ? $clog2(NOTE_CYC) : 1;
  localparam int unsigned HP_W   = (HP_MAX > 2) ? $clog2(HP_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_BATT  = 3'd2,
    S_OVR   = 3'd3,
    S_BOTH  = 3'd4,
    S_CHIME = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fc_q;
  logic [NC_W-1:0]   nc_q;
  logic [1:0]        ni_q;
  logic [HP_W-1:0]   hp_cnt_q;
  logic              tone_q;
  logic              chime_pend_q, pend_d;
  logic              warn, note_last, chime_done, note_change, state_chg;
  logic [HP_W-1:0]   hp_m1;
  logic              gate;
  logic              in_q0, in_q2, in_q3;

  // Arbitration, chime bookkeeping and per-state tone/gate decode
  always_comb begin
    state_d     = S_IDLE;
    pend_d      = chime_pend_q;
    hp_m1       = '0;
    gate        = 1'b0;
    warn        = ovr_spd | batt_low;
    note_last   = (nc_q == NC_W'(NOTE_CYC - 1));
    // a warning landing on the final note edge keeps the chime pending for a replay
    chime_done  = (state_q == S_CHIME) && (ni_q == 2'd2) && note_last && !warn;
    in_q0       = (fc_q < FC_W'(Q));
    in_q2       = (fc_q >= FC_W'(2 * Q)) && (fc_q < FC_W'(3 * Q));
    in_q3       = (fc_q >= FC_W'(3 * Q));

    if (chime_done)     pend_d = 1'b0;
    else if (chime_req) pend_d = 1'b1;

    if (ovr_spd && batt_low)            state_d = S_BOTH;
    else if (ovr_spd)                   state_d = S_OVR;
    else if (batt_low)                  state_d = S_BATT;
    else if (chime_pend_q && !chime_done) state_d = S_CHIME;
    else if (norm_mode)                 state_d = S_NORM;

    state_chg   = (state_d != state_q);
    note_change = (state_q == S_CHIME) && !state_chg && note_last;

    case (state_q)
      S_NORM: begin
        hp_m1 = HP_W'(HP_NORM - 1);
        gate  = in_q3;
      end
      S_BATT: begin
        hp_m1 = HP_W'(HP_BATT - 1);
        gate  = in_q3;
      end
      S_OVR: begin
        hp_m1 = HP_W'(HP_OVR - 1);
        gate  = in_q0 | in_q2;
      end
      S_BOTH: begin
        hp_m1 = HP_W'(HP_OVR / 2 - 1);
        gate  = in_q0 | in_q2;
      end
      S_CHIME: begin
        gate = 1'b1;
        case (ni_q)
          2'd0:    hp_m1 = HP_W'(HP_NORM - 1);
          2'd1:    hp_m1 = HP_W'(HP_BATT - 1);
          default: hp_m1 = HP_W'(HP_OVR - 1);
        endcase
      end
      default: begin
        hp_m1 = '0;
        gate  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fc_q         <= '0;
      nc_q         <= '0;
      ni_q         <= '0;
      hp_cnt_q     <= '0;
      tone_q       <= 1'b0;
      chime_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chime_pend_q <= pend_d;
      fc_q         <= (fc_q == FC_W'(FRAME_CYC - 1)) ? '0 : fc_q + FC_W'(1);

      // Note sequencing restarts from note 0 whenever CHIME is entered or left
      if ((state_q != S_CHIME) || state_chg) begin
        nc_q <= '0;
        ni_q <= '0;
      end else if (note_last) begin
        nc_q <= '0;
        ni_q <= ni_q + 2'd1;
      end else begin
        nc_q <= nc_q + NC_W'(1);
      end

      if (state_chg || note_change) begin
        hp_cnt_q <= '0;
        tone_q   <= 1'b0;
      end else if (state_q != S_IDLE) begin
        if (hp_cnt_q == hp_m1) begin
          hp_cnt_q <= '0;
          tone_q   <= ~tone_q;
        end else begin
          hp_cnt_q <= hp_cnt_q + HP_W'(1);
        end
      end
    end
  end

  assign piezo   = tone_q & gate;
  assign piezo_n = ~piezo;
  assign busy    = chime_pend_q;
  assign src     = state_q;

endmodule

// File: tb/tb_piezo_sched.sv
// tb_piezo_sched: directed scenarios for the buzzer alert scheduler with small
// frame/note/half-period parameters and hand-derived expectations.
module tb_piezo_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       norm_mode = 1'b0;
  logic       ovr_spd = 1'b0;
  logic       batt_low = 1'b0;
  logic       chime_req = 1'b0;
  logic       piezo, piezo_n, busy;
  logic [2:0] src;

  int n_cmp = 0;
  int n_err = 0;

  piezo_sched #(
    .FRAME_CYC(64),
    .NOTE_CYC (40),
    .HP_NORM  (8),
    .HP_BATT  (4),
    .HP_OVR   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .norm_mode(norm_mode),
    .ovr_spd  (ovr_spd),
    .batt_low (batt_low),
    .chime_req(chime_req),
    .piezo    (piezo),
    .piezo_n  (piezo_n),
    .busy     (busy),
    .src      (src)
  );

  always #5 clk = ~clk;

  // Frame windows for n = edges since reset release (fc = n mod 64)
  function automatic logic gate_ovr(int n);
    int f;
    f = n % 64;
    return (f < 16) || ((f >= 32) && (f < 48));
  endfunction

  function automatic logic gate_hi(int n);
    return (n % 64) >= 48;
  endfunction

  // Square wave level k edges after entry, low for the first hp cycles
  function automatic logic sq(int k, int hp);
    return ((k / hp) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges; edge 1 is the first posedge after return
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    norm_mode = 0; ovr_spd = 0; batt_low = 0; chime_req = 0;
    do_reset();
    n_cmp++;
    if ({piezo, piezo_n, busy, src} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_vals: got piezo=%b piezo_n=%b busy=%b src=%0d want 0 1 0 0", piezo, piezo_n, busy, src);
    end
    for (int n = 1; n <= 200; n++) begin
      tick();
      n_cmp++;
      if ({piezo, piezo_n, busy, src} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
        n_err++;
        $display("FAIL idle_hold n=%0d: got piezo=%b piezo_n=%b busy=%b src=%0d want 0 1 0 0", n, piezo, piezo_n, busy, src);
      end
    end
  endtask

  task automatic test_norm();
    logic e;
    norm_mode = 1; ovr_spd = 0; batt_low = 0; chime_req = 0;
    do_reset();
    for (int n = 1; n <= 192; n++) begin
      tick();
      e = gate_hi(n) && sq(n - 1, 8);
      n_cmp++;
      if ({src, piezo, piezo_n} !== {3'd1, e, ~e}) begin
        n_err++;
        $display("FAIL norm n=%0d: got src=%0d piezo=%b piezo_n=%b want src=1 piezo=%b", n, src, piezo, piezo_n, e);
      end
    end
    norm_mode = 0;
  endtask

  task automatic test_chime();
    logic e;
    norm_mode = 0; ovr_spd = 0; batt_low = 0; chime_req = 0;
    do_reset();
    repeat (3) tick();
    chime_req = 1;
    tick();
    chime_req = 0;
    n_cmp++;
    if ({busy, src} !== {1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL chime_req_busy: got busy=%b src=%0d want busy=1 src=0", busy, src);
    end
    for (int k = 0; k < 120; k++) begin
      tick();
      e = sq(k % 40, (k < 40) ? 8 : ((k < 80) ? 4 : 2));
      n_cmp++;
      if ({src, busy, piezo, piezo_n} !== {3'd5, 1'b1, e, ~e}) begin
        n_err++;
        $display("FAIL chime k=%0d: got src=%0d busy=%b piezo=%b piezo_n=%b want src=5 busy=1 piezo=%b", k, src, busy, piezo, piezo_n, e);
      end
    end
    tick();
    n_cmp++;
    if ({src, busy, piezo, piezo_n} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL chime_end: got src=%0d busy=%b piezo=%b want src=0 busy=0 piezo=0", src, busy, piezo);
    end
  endtask

  task automatic test_preempt();
    logic e;
    norm_mode = 0; ovr_spd = 0; batt_low = 0; chime_req = 0;
    do_reset();
    repeat (3) tick();
    chime_req = 1;
    tick();
    chime_req = 0;
    // chime entered at edge 5; over-speed sampled at edge 55 (50 cycles in)
    repeat (50) tick();
    ovr_spd = 1;
    for (int n = 55; n < 160; n++) begin
      tick();
      e = gate_ovr(n) && sq(n - 55, 2);
      n_cmp++;
      if ({src, busy, piezo, piezo_n} !== {3'd3, 1'b1, e, ~e}) begin
        n_err++;
        $display("FAIL preempt_ovr n=%0d: got src=%0d busy=%b piezo=%b want src=3 busy=1 piezo=%b", n, src, busy, piezo, e);
      end
    end
    ovr_spd = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      e = sq(k % 40, (k < 40) ? 8 : ((k < 80) ? 4 : 2));
      n_cmp++;
      if ({src, busy, piezo, piezo_n} !== {3'd5, 1'b1, e, ~e}) begin
        n_err++;
        $display("FAIL replay k=%0d: got src=%0d busy=%b piezo=%b want src=5 busy=1 piezo=%b", k, src, busy, piezo, e);
      end
    end
    tick();
    n_cmp++;
    if ({src, busy} !== {3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL replay_end: got src=%0d busy=%b want src=0 busy=0", src, busy);
    end
  endtask

  task automatic test_both();
    logic e;
    norm_mode = 0; ovr_spd = 1; batt_low = 1; chime_req = 0;
    do_reset();
    for (int n = 1; n <= 128; n++) begin
      tick();
      e = gate_ovr(n) && sq(n - 1, 1);
      n_cmp++;
      if ({src, piezo, piezo_n} !== {3'd4, e, ~e}) begin
        n_err++;
        $display("FAIL both n=%0d: got src=%0d piezo=%b want src=4 piezo=%b", n, src, piezo, e);
      end
    end
    ovr_spd = 0;
    for (int n = 129; n <= 256; n++) begin
      tick();
      e = gate_hi(n) && sq(n - 129, 4);
      n_cmp++;
      if ({src, piezo, piezo_n} !== {3'd2, e, ~e}) begin
        n_err++;
        $display("FAIL batt n=%0d: got src=%0d piezo=%b want src=2 piezo=%b", n, src, piezo, e);
      end
    end
    batt_low = 0;
  endtask

  task automatic test_simul();
    norm_mode = 0; ovr_spd = 0; batt_low = 0; chime_req = 0;
    do_reset();
    repeat (2) tick();
    chime_req = 1;
    ovr_spd   = 1;
    tick();
    chime_req = 0;
    n_cmp++;
    if ({src, busy} !== {3'd3, 1'b1}) begin
      n_err++;
      $display("FAIL req_with_warn: got src=%0d busy=%b want src=3 busy=1", src, busy);
    end
    repeat (2) tick();
    ovr_spd = 0;
    tick();
    n_cmp++;
    if ({src, busy, piezo} !== {3'd5, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL chime_after_warn: got src=%0d busy=%b piezo=%b want src=5 busy=1 piezo=0", src, busy, piezo);
    end
    repeat (119) tick();
    n_cmp++;
    if ({src, busy} !== {3'd5, 1'b1}) begin
      n_err++;
      $display("FAIL last_note_cycle: got src=%0d busy=%b want src=5 busy=1", src, busy);
    end
    // warning rises on the final note edge
    ovr_spd = 1;
    tick();
    n_cmp++;
    if ({src, busy} !== {3'd3, 1'b1}) begin
      n_err++;
      $display("FAIL note_end_warn: got src=%0d busy=%b want src=3 busy=1", src, busy);
    end
    ovr_spd = 0;
    tick();
    n_cmp++;
    if ({src, busy, piezo} !== {3'd5, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL restart_entry: got src=%0d busy=%b piezo=%b want src=5 busy=1 piezo=0", src, busy, piezo);
    end
    repeat (8) tick();
    n_cmp++;
    if ({src, piezo, piezo_n} !== {3'd5, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL restart_first_rise: got src=%0d piezo=%b piezo_n=%b want src=5 piezo=1 piezo_n=0", src, piezo, piezo_n);
    end
    repeat (111) tick();
    n_cmp++;
    if ({src, busy} !== {3'd5, 1'b1}) begin
      n_err++;
      $display("FAIL restart_full_len: got src=%0d busy=%b want src=5 busy=1", src, busy);
    end
    tick();
    n_cmp++;
    if ({src, busy} !== {3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL restart_end: got src=%0d busy=%b want src=0 busy=0", src, busy);
    end
  endtask

  task automatic test_reset_mid();
    norm_mode = 0; ovr_spd = 0; batt_low = 0; chime_req = 0;
    do_reset();
    repeat (3) tick();
    chime_req = 1;
    tick();
    chime_req = 0;
    // 55 edges reach chime cycle 54: note 1, offset 14, tone high
    repeat (55) tick();
    n_cmp++;
    if ({src, busy, piezo} !== {3'd5, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset_tone: got src=%0d busy=%b piezo=%b want src=5 busy=1 piezo=1", src, busy, piezo);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({src, busy, piezo, piezo_n} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got src=%0d busy=%b piezo=%b piezo_n=%b want 0 0 0 1", src, busy, piezo, piezo_n);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      n_cmp++;
      if ({src, busy, piezo, piezo_n} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL post_reset n=%0d: got src=%0d busy=%b piezo=%b want 0 0 0", n, src, busy, piezo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_norm();
    test_chime();
    test_preempt();
    test_both();
    test_simul();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
